fetch_queue: RTL and testbench

Instruction buffer between the fetcher and the decoder. Accepts one `{pc, inst}` packet per cycle from fetch with a valid/ready handshake, holds up to `DEPTH` packets in order, and presents the oldest to decode. A decode stall therefore does not force fetch to hold the PC combinationally. A branch/jump redirect from the writeback-to-forward path flushes all buffered packets.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue.sv | 83 ++++++++
 tb/tb_fetch_queue.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer.
package fetch_queue_pkg;

    localparam int BIN_DIG  = 32;
    localparam int FQ_DEPTH = 4;

    typedef struct packed {
        logic [BIN_DIG-1:0] pc;
        logic [BIN_DIG-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of {pc, inst} packets between fetch and decode.
// A flush (redirect) empties the queue and wins over any push or pop that
// happens in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int W     = BIN_DIG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_pc,
    input  logic [W-1:0]             in_inst,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_pc,
    output logic [W-1:0]             out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_pkt_t      mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   count_q;
    logic            push;
    logic            pop;

    // Handshake qualification; ready depends only on registered occupancy,
    // so a full queue never passes a packet through on a same-cycle pop.
    always_comb begin
        in_ready  = (count_q != CW'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        count     = count_q;
    end

    // Head presentation; zero while empty so stale storage stays hidden.
    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (out_valid) begin
            out_pc   = mem[rp].pc;
            out_inst = mem[rp].inst;
        end
    end

    // Packet storage; not reset, contents are only visible through rp.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp].pc   <= in_pc;
            mem[wp].inst <= in_inst;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: table of single-cycle vectors plus
// hand-written sequences for streaming/wrap, flush and async reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [2:0]  e_cnt;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t tbl [9];

    fetch_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0000_0013 | (pc << 12);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic chk_all(input string tag, input logic e_ov, input logic e_ir,
                           input logic [2:0] e_cnt, input logic [31:0] e_pc,
                           input logic [31:0] e_inst);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
        chk({tag, ".count"},     {29'd0, count},     {29'd0, e_cnt});
        chk({tag, ".out_pc"},    out_pc,   e_pc);
        chk({tag, ".out_inst"},  out_inst, e_inst);
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // single packet, fill to full, rejected fifth push, in-order drain
        tbl[0] = '{1'b1, 32'h0,  32'h00500093, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 32'h0,  32'h00500093};
        tbl[1] = '{1'b1, 32'h4,  32'h00400113, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 32'h0,  32'h00500093};
        tbl[2] = '{1'b1, 32'h8,  32'h00300193, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 32'h0,  32'h00500093};
        tbl[3] = '{1'b1, 32'hC,  32'h00200213, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0,  32'h00500093};
        tbl[4] = '{1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0,  32'h00500093};
        tbl[5] = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 32'h4,  32'h00400113};
        tbl[6] = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 32'h8,  32'h00300193};
        tbl[7] = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 32'hC,  32'h00200213};
        tbl[8] = '{1'b0, 32'h0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0,  32'h0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // reset then idle
        #12;
        chk_all("in_reset", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk_all("after_reset", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].fl, tbl[i].ordy);
            chk_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir,
                    tbl[i].e_cnt, tbl[i].e_pc, tbl[i].e_inst);
        end

        // streaming across three pointer wraps: output is input delayed one cycle
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 32'(4 * k), inst_of(32'(4 * k)), 1'b0, 1'b1);
            chk_all($sformatf("stream%0d", k), 1'b1, 1'b1, 3'd1,
                    32'(4 * k), inst_of(32'(4 * k)));
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk_all("stream_drain", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);

        // flush wins over simultaneous push and pop
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h100 + 32'(4 * k), inst_of(32'h100 + 32'(4 * k)), 1'b0, 1'b0);
        chk_all("pre_flush", 1'b1, 1'b1, 3'd3, 32'h100, inst_of(32'h100));
        step(1'b1, 32'h40, inst_of(32'h40), 1'b1, 1'b1);
        chk_all("flush", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);
        step(1'b1, 32'h80, inst_of(32'h80), 1'b0, 1'b0);
        chk_all("post_flush_push", 1'b1, 1'b1, 3'd1, 32'h80, inst_of(32'h80));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk_all("post_flush_alone", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);

        // async reset between edges with two packets held
        step(1'b1, 32'h200, inst_of(32'h200), 1'b0, 1'b0);
        step(1'b1, 32'h204, inst_of(32'h204), 1'b0, 1'b0);
        in_valid = 1'b0;
        chk_all("pre_reset", 1'b1, 1'b1, 3'd2, 32'h200, inst_of(32'h200));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 1'b1, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h300, inst_of(32'h300), 1'b0, 1'b0);
        chk_all("first_after_release", 1'b1, 1'b1, 3'd1, 32'h300, inst_of(32'h300));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
